// File: rtl/icache_if.sv
// Datapath-fetch and memory-fill signals of the instruction cache, bundled for port use.
// The cache takes the slave side; the datapath/memory environment takes the master side.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-latency hits
// and a two-state (IDLE/FETCH) miss handler that fills from memory.
module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input logic     CLK,
    input logic     RST,
    icache_if.slave bus
);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags [SETS];
    logic [31:0]        data [SETS];
    logic [31:0]        miss_addr;
    logic               iren;
    logic [31:0]        hit_count;
    logic [31:0]        miss_count;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   miss_idx;
    logic               hit;
    logic               fill;

    assign idx      = bus.imemaddr[IDX_W+1:2];
    assign tag      = bus.imemaddr[31:IDX_W+2];
    assign miss_idx = miss_addr[IDX_W+1:2];

    assign hit  = (state == IDLE) && bus.imemREN && valid[idx]
                  && (tags[idx] == tag) && !bus.flush;
    // A flush in the completing cycle wins over the returning data.
    assign fill = (state == FETCH) && !bus.flush && !bus.iwait;

    assign bus.ihit       = hit;
    assign bus.imemload   = hit ? data[idx] : 32'd0;
    assign bus.iREN       = iren;
    assign bus.iaddr      = iren ? miss_addr : 32'd0;
    assign bus.hit_count  = hit_count;
    assign bus.miss_count = miss_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= 32'd0;
            iren       <= 1'b0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit)
                hit_count <= hit_count + 32'd1;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (bus.imemREN && !hit) begin
                        state     <= FETCH;
                        miss_addr <= bus.imemaddr;
                        iren      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.flush) begin
                        valid <= '0;
                        state <= IDLE;
                        iren  <= 1'b0;
                    end else if (!bus.iwait) begin
                        valid[miss_idx] <= 1'b1;
                        state           <= IDLE;
                        iren            <= 1'b0;
                        miss_count      <= miss_count + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    iren  <= 1'b0;
                end
            endcase
        end
    end

    // Frame payload is not reset; the valid bits alone qualify it.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[miss_idx] <= miss_addr[31:IDX_W+2];
            data[miss_idx] <= bus.iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized reads
// compared against an abstract frame-table model of the cache.
module tb_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;

    icache_if bus ();

    icache #(.SETS(16), .IDX_W(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-index valid/tag/data, plus expected counters.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [31:0] exp_hits = 32'd0;
    logic [31:0] exp_miss = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_counters(input string name);
        chk({name, "_hit_count"}, bus.hit_count, exp_hits);
        chk({name, "_miss_count"}, bus.miss_count, exp_miss);
    endtask

    // One datapath read of addr; on a miss memory answers after nwait busy cycles.
    task automatic do_read(input logic [31:0] addr, input int nwait, input bit scramble);
        int          i;
        logic        exp_hit;
        i       = int'(addr[5:2]);
        exp_hit = m_valid[i] && (m_tag[i] == addr[31:6]);
        @(negedge clk);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.flush    = 1'b0;
        bus.iwait    = 1'b1;
        #1;
        chk("idle_iREN", {31'd0, bus.iREN}, 32'd0);
        if (exp_hit) begin
            chk("hit_ihit", {31'd0, bus.ihit}, 32'd1);
            chk("hit_data", bus.imemload, m_data[i]);
            exp_hits++;
            return;
        end
        chk("miss_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("miss_load", bus.imemload, 32'd0);
        for (int k = 0; k <= nwait; k++) begin
            @(negedge clk);
            bus.iwait = (k < nwait);
            bus.iload = (k == nwait) ? mem_word(addr) : $urandom;
            if (scramble) begin
                bus.imemREN  = 1'($urandom);
                bus.imemaddr = $urandom;
            end
            #1;
            chk("fetch_iREN", {31'd0, bus.iREN}, 32'd1);
            chk("fetch_iaddr", bus.iaddr, addr);
            chk("fetch_ihit", {31'd0, bus.ihit}, 32'd0);
        end
        m_valid[i] = 1'b1;
        m_tag[i]   = addr[31:6];
        m_data[i]  = mem_word(addr);
        exp_miss++;
        @(negedge clk);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        #1;
        chk("refill_hit", {31'd0, bus.ihit}, 32'd1);
        chk("refill_data", bus.imemload, m_data[i]);
        chk("refill_iaddr", bus.iaddr, 32'd0);
        exp_hits++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'd0;
        bus.flush    = 1'b0;
        bus.iwait    = 1'b1;
        bus.iload    = 32'd0;
        model_clear();

        // Reset state
        #1;
        chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("rst_iREN", {31'd0, bus.iREN}, 32'd0);
        chk("rst_iaddr", bus.iaddr, 32'd0);
        chk("rst_imemload", bus.imemload, 32'd0);
        check_counters("rst");
        @(negedge clk);
        rst = 1'b0;

        // Cold miss with two busy cycles, then five repeat hits
        do_read(32'h0000_0040, 2, 1'b0);
        chk("cold_data", m_data[0], mem_word(32'h40));
        @(negedge clk); bus.imemREN = 1'b0; #1;
        check_counters("cold");
        for (int r = 0; r < 5; r++) do_read(32'h0000_0040, 0, 1'b0);
        @(negedge clk); bus.imemREN = 1'b0; #1;
        chk("repeat_hits", bus.hit_count, 32'd6);

        // Conflict on index 0 evicts 0x40
        do_read(32'h0000_0080, 1, 1'b1);
        do_read(32'h0000_0040, 0, 1'b0);
        @(negedge clk); bus.imemREN = 1'b0; #1;
        chk("conflict_miss", bus.miss_count, 32'd3);

        // imemREN low on a valid address: no hit, no change
        @(negedge clk);
        bus.imemREN = 1'b0; bus.imemaddr = 32'h40; #1;
        chk("noreq_ihit", {31'd0, bus.ihit}, 32'd0);
        @(negedge clk); #1;
        chk("noreq_iREN", {31'd0, bus.iREN}, 32'd0);
        check_counters("noreq");

        // Flush in the completing FETCH cycle aborts the fill
        @(negedge clk);
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0104; bus.iwait = 1'b1; #1;
        chk("fl_miss", {31'd0, bus.ihit}, 32'd0);
        @(negedge clk);
        bus.iwait = 1'b0; bus.flush = 1'b1; bus.iload = mem_word(32'h104); #1;
        chk("fl_fetch_iREN", {31'd0, bus.iREN}, 32'd1);
        @(negedge clk);
        bus.flush = 1'b0; bus.imemREN = 1'b0; bus.iwait = 1'b1; #1;
        chk("fl_after_iREN", {31'd0, bus.iREN}, 32'd0);
        model_clear();
        check_counters("fl_fetch");
        do_read(32'h0000_0104, 0, 1'b0);
        do_read(32'h0000_0040, 1, 1'b0);

        // Flush in IDLE masks a would-be hit and invalidates everything
        @(negedge clk);
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0104; bus.flush = 1'b1; #1;
        chk("fl_idle_ihit", {31'd0, bus.ihit}, 32'd0);
        chk("fl_idle_load", bus.imemload, 32'd0);
        model_clear();
        @(negedge clk); bus.flush = 1'b0; bus.imemREN = 1'b0; #1;
        chk("fl_idle_iREN", {31'd0, bus.iREN}, 32'd0);
        check_counters("fl_idle");
        do_read(32'h0000_0104, 0, 1'b0);

        // Randomized reads over a small tag pool to mix hits, misses and conflicts
        for (int n = 0; n < 80; n++) begin
            a = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
            a = a | {4'($urandom_range(0, 1)), 28'd0};
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                bus.imemREN = 1'($urandom); bus.imemaddr = a; bus.flush = 1'b1; #1;
                chk("rnd_flush_ihit", {31'd0, bus.ihit}, 32'd0);
                model_clear();
                @(negedge clk); bus.flush = 1'b0; bus.imemREN = 1'b0;
            end
            do_read(a, $urandom_range(0, 3), 1'($urandom));
        end
        @(negedge clk); bus.imemREN = 1'b0; #1;
        check_counters("rnd");

        // Reset in the middle of a fill
        do_read(32'h0000_0040, 0, 1'b0);
        @(negedge clk);
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0200; bus.iwait = 1'b1; #1;
        @(negedge clk); #1;
        chk("rstmid_fetch", {31'd0, bus.iREN}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_iREN", {31'd0, bus.iREN}, 32'd0);
        chk("rstmid_iaddr", bus.iaddr, 32'd0);
        model_clear();
        exp_hits = 32'd0;
        exp_miss = 32'd0;
        check_counters("rstmid");
        @(negedge clk);
        rst = 1'b0; bus.iwait = 1'b0; bus.iload = mem_word(32'h200); bus.imemREN = 1'b0;
        do_read(32'h0000_0040, 1, 1'b0);
        do_read(32'h0000_0200, 0, 1'b0);
        @(negedge clk); bus.imemREN = 1'b0; #1;
        check_counters("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001: Parameter SETS, default 16, number of direct-mapped frames (power of two, 2..256).
REQ-002: Parameter IDX_W, default 4, index width, SHALL equal log2(SETS).
REQ-003: CLK  input  1  rising-edge clock.
REQ-004: RST  input  1  reset, asynchronous, active-high.
REQ-005: imemREN  input  1  datapath instruction read request.
REQ-006: imemaddr  input  32  datapath fetch address (word-aligned).
REQ-007: flush  input  1  invalidate all frames.
REQ-008: ihit  output  1  imemload valid this cycle.
REQ-009: imemload  output  32  instruction to datapath.
REQ-010: iREN  output  1  memory read request.
REQ-011: iaddr  output  32  memory read address.
REQ-012: iwait  input  1  memory busy; data valid when iREN=1 and iwait=0.
REQ-013: iload  input  32  memory read data.
REQ-014: hit_count  output  32  completed hits.
REQ-015: miss_count  output  32  completed fills.

Function
REQ-016: Address split SHALL be tag=imemaddr[31:IDX_W+2], index=imemaddr[IDX_W+1:2]; bits [1:0] ignored.
REQ-017: Each frame SHALL hold valid bit, tag, one 32-bit data word.
REQ-018: FSM states SHALL be IDLE and FETCH only.
REQ-019: IDLE, hit = imemREN & valid[index] & tag match & !flush; ihit SHALL be combinational (zero-cycle latency), imemload=frame data.
REQ-020: IDLE, imemREN & !hit & !flush -> FETCH next edge; imemaddr SHALL be latched into miss_addr on that edge.
REQ-021: FETCH: iREN=1, iaddr=miss_addr; ihit=0 regardless of imemaddr.
REQ-022: FETCH & !iwait: frame[miss_addr index] SHALL be written valid=1, tag, data=iload; state -> IDLE; miss_count increments.
REQ-023: Hit on the filled address SHALL occur the cycle after fill; miss latency = memory cycles + 1.
REQ-024: imemREN deassertion or imemaddr change during FETCH SHALL NOT abort the fill.
REQ-025: Outside FETCH, iREN=0 and iaddr=0; with ihit=0, imemload=0.
REQ-026: flush in IDLE SHALL clear all valid bits next edge; ihit forced 0 that cycle.
REQ-027: flush in FETCH SHALL abort: no frame write, all valid cleared, state -> IDLE, miss_count unchanged, even if iwait=0 that cycle.
REQ-028: Conflict (same index, different tag) SHALL miss and overwrite the frame.
REQ-029: hit_count SHALL increment on each cycle ihit=1; both counters wrap modulo 2^32.

Reset
REQ-030: RST=1 SHALL immediately force state IDLE, all valid bits 0, miss_addr 0, both counters 0, ihit 0, iREN 0, iaddr 0, imemload 0; tags and data need not reset.
REQ-031: RST mid-FETCH SHALL abandon the fill with no frame write.
REQ-032: After RST deasserts, first edge SHALL operate normally.

Verification
REQ-033: Cold read 0x0000_0040 with 2-cycle iwait, iload=0x2001_0005 -> iREN,iaddr=0x40 for 3 cycles, next cycle ihit=1, imemload=0x2001_0005, miss_count=1, hit_count=1.
REQ-034: Repeat 0x40 for 5 cycles -> ihit=1 each, iREN=0, hit_count=+5.
REQ-035: After 0x40 filled, read 0x0000_0080 (same index, SETS=16) -> miss; then 0x40 misses again; miss_count=3.
REQ-036: flush asserted in FETCH cycle with iwait=0 -> no write, next read of that address misses, miss_count unchanged.
REQ-037: RST pulsed mid-FETCH -> iREN=0 immediately; post-reset read of earlier-hit address misses; counters 0.
REQ-038: imemREN=0, valid matching address -> ihit=0, hit_count unchanged, no state change.
